// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: RAW scoreboard, redirect squash, memory freeze
// and HALT drain sequencing for the ID/EX boundary.
module id_issue_ctrl #(
   parameter int WB_DIST  = 2,
   parameter int BR_FLUSH = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [2:0]  id_rs,
   input  logic        id_rs_used,
   input  logic [2:0]  id_rt,
   input  logic        id_rt_used,
   input  logic        id_wr_en,
   input  logic [2:0]  id_wr_reg,
   input  logic        id_halt,
   input  logic        ex_redirect,
   input  logic        mem_busy,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        pipe_freeze,
   output logic        issue,
   output logic        halted,
   output logic [15:0] stall_cnt
);

   localparam int PW = (WB_DIST < 1) ? 1 : $clog2(WB_DIST + 1);
   localparam int FW = $clog2(BR_FLUSH + 1);
   localparam logic [PW-1:0] PEND_LOAD  = PW'(WB_DIST);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(BR_FLUSH - 1);

   typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

   state_t        state;
   logic [PW-1:0] pend [8];
   logic [PW-1:0] pend_nxt [8];
   logic [FW-1:0] flush_cnt;
   logic [15:0]   stall_q;
   logic          halted_q;

   logic hazard, stall_inc, pend_idle;
   logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c, pipe_freeze_c, issue_c;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign hazard = id_valid & ((id_rs_used & (pend[id_rs] != '0)) |
                               (id_rt_used & (pend[id_rt] != '0)));

   always_comb begin
      pc_stall_c    = 1'b0;
      ifid_stall_c  = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
      pipe_freeze_c = 1'b0;
      issue_c       = 1'b0;
      stall_inc     = 1'b0;
      case (state)
         RUN: begin
            if (ex_redirect) begin
               ifid_flush_c  = 1'b1;
               idex_bubble_c = 1'b1;
            end else if (mem_busy) begin
               pipe_freeze_c = 1'b1;
               pc_stall_c    = 1'b1;
               ifid_stall_c  = 1'b1;
            end else if (hazard) begin
               pc_stall_c    = 1'b1;
               ifid_stall_c  = 1'b1;
               idex_bubble_c = 1'b1;
               stall_inc     = 1'b1;
            end else begin
               issue_c = id_valid;
            end
         end
         FLUSH: begin
            idex_bubble_c = 1'b1;
            if (ex_redirect) begin
               ifid_flush_c = 1'b1;
            end else if (mem_busy) begin
               pipe_freeze_c = 1'b1;
               pc_stall_c    = 1'b1;
               ifid_stall_c  = 1'b1;
               idex_bubble_c = 1'b0;
            end
         end
         default: begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            pipe_freeze_c = mem_busy;
         end
      endcase
   end

   // A same-cycle reload by the issuing writer wins over the decrement.
   always_comb begin
      pend_idle = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pend_nxt[i] = pend[i];
         if (!pipe_freeze_c) begin
            if (issue_c && id_wr_en && (id_wr_reg == 3'(i)))
               pend_nxt[i] = PEND_LOAD;
            else if (pend[i] != '0)
               pend_nxt[i] = pend[i] - PW'(1);
         end
         if (pend_nxt[i] != '0)
            pend_idle = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         flush_cnt <= '0;
         stall_q   <= '0;
         halted_q  <= 1'b0;
         for (int i = 0; i < 8; i++)
            pend[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++)
            pend[i] <= pend_nxt[i];
         if (stall_inc)
            stall_q <= sat_inc(stall_q);
         case (state)
            RUN: begin
               if (ex_redirect) begin
                  flush_cnt <= FLUSH_LOAD;
                  if (BR_FLUSH > 1)
                     state <= FLUSH;
               end else if (issue_c && id_halt) begin
                  state <= HALT;
               end
            end
            FLUSH: begin
               if (ex_redirect)
                  flush_cnt <= FLUSH_LOAD;
               else if (!mem_busy) begin
                  if (flush_cnt <= FW'(1))
                     state <= RUN;
                  else
                     flush_cnt <= flush_cnt - FW'(1);
               end
            end
            default: begin
               // Drained means nothing still pending once this cycle's decrement lands.
               if (!mem_busy && pend_idle)
                  halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign pc_stall    = rst & pc_stall_c;
   assign ifid_stall  = rst & ifid_stall_c;
   assign ifid_flush  = rst & ifid_flush_c;
   assign idex_bubble = ~rst | idex_bubble_c;
   assign pipe_freeze = rst & pipe_freeze_c;
   assign issue       = rst & issue_c;
   assign halted      = rst & halted_q;
   assign stall_cnt   = rst ? stall_q : 16'd0;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: reset, RAW stalls, freeze, redirect,
// back-to-back writers and HALT drain with hand-derived cycle expectations.
module tb_id_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt;
   logic [2:0]  id_rs, id_rt, id_wr_reg;
   logic        ex_redirect, mem_busy;
   logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, issue, halted;
   logic [15:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_issue_ctrl #(.WB_DIST(2), .BR_FLUSH(1)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_halt(id_halt),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .issue(issue),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change just after the edge; checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
      id_wr_en = 0; id_wr_reg = 0; id_halt = 0; ex_redirect = 0; mem_busy = 0;
   endtask

   task automatic instr(input logic [2:0] rs, input logic rsu, input logic [2:0] wr,
                        input logic we, input logic h);
      idle();
      id_valid = 1; id_rs = rs; id_rs_used = rsu; id_wr_reg = wr; id_wr_en = we; id_halt = h;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      tick();
      rst = 1;
   endtask

   initial begin
      idle();
      rst = 0;
      #1;
      // Reset: outputs forced even with a valid instr presented
      id_valid = 1;
      settle();
      chk("rst_issue", issue, 0);
      chk("rst_bubble", idex_bubble, 1);
      chk("rst_pcstall", pc_stall, 0);
      tick();
      tick();
      chk("rst_stallcnt", stall_cnt, 0);
      chk("rst_halted", halted, 0);
      rst = 1;
      instr(3'd1, 1, 3'd0, 0, 0);
      settle();
      chk("first_issue", issue, 1);
      chk("first_bubble", idex_bubble, 0);
      tick();

      // Writer r3 at t, reader r3 stalls t+1,t+2, issues t+3
      instr(3'd0, 0, 3'd3, 1, 0);
      settle(); chk("raw_w_issue", issue, 1);
      tick();
      instr(3'd3, 1, 3'd0, 0, 0);
      settle(); chk("raw_t1_issue", issue, 0); chk("raw_t1_pcstall", pc_stall, 1);
      chk("raw_t1_ifid", ifid_stall, 1); chk("raw_t1_bub", idex_bubble, 1);
      tick();
      settle(); chk("raw_t2_issue", issue, 0);
      tick();
      settle(); chk("raw_t3_issue", issue, 1); chk("raw_stallcnt", stall_cnt, 2);
      tick();

      // Reset mid-hazard clears the scoreboard
      instr(3'd0, 0, 3'd3, 1, 0);
      tick();
      do_reset();
      instr(3'd3, 1, 3'd0, 0, 0);
      settle(); chk("rstmid_issue", issue, 1); chk("rstmid_cnt", stall_cnt, 0);
      tick();

      // RAW with mem_busy at t+2..t+4
      do_reset();
      instr(3'd0, 0, 3'd3, 1, 0);
      tick();
      instr(3'd3, 1, 3'd0, 0, 0);
      settle(); chk("frz_t1_issue", issue, 0);
      tick();
      mem_busy = 1;
      settle(); chk("frz_t2_freeze", pipe_freeze, 1); chk("frz_t2_bub", idex_bubble, 0);
      chk("frz_t2_issue", issue, 0); chk("frz_t2_pcstall", pc_stall, 1);
      tick();
      settle(); chk("frz_t3_freeze", pipe_freeze, 1);
      tick();
      settle(); chk("frz_t4_freeze", pipe_freeze, 1);
      tick();
      mem_busy = 0;
      settle(); chk("frz_t5_issue", issue, 0); chk("frz_t5_bub", idex_bubble, 1);
      tick();
      settle(); chk("frz_t6_issue", issue, 1); chk("frz_stallcnt", stall_cnt, 2);
      tick();

      // ex_redirect overrides a hazarded reader
      do_reset();
      instr(3'd0, 0, 3'd3, 1, 0);
      tick();
      instr(3'd3, 1, 3'd0, 0, 0);
      ex_redirect = 1;
      settle(); chk("br_flush", ifid_flush, 1); chk("br_bub", idex_bubble, 1);
      chk("br_issue", issue, 0); chk("br_pcstall", pc_stall, 0);
      tick();
      instr(3'd6, 1, 3'd0, 0, 0);
      settle(); chk("br_cnt", stall_cnt, 0); chk("br_run_issue", issue, 1);
      chk("br_noflush", ifid_flush, 0);
      tick();

      // Back-to-back writers to r2, reader on rt
      do_reset();
      instr(3'd0, 0, 3'd2, 1, 0);
      tick();
      instr(3'd0, 0, 3'd2, 1, 0);
      settle(); chk("waw_issue", issue, 1);
      tick();
      instr(3'd0, 0, 3'd0, 0, 0);
      id_rt = 3'd2; id_rt_used = 1;
      settle(); chk("waw_t2_issue", issue, 0);
      tick();
      settle(); chk("waw_t3_issue", issue, 0);
      tick();
      settle(); chk("waw_t4_issue", issue, 1); chk("waw_cnt", stall_cnt, 2);
      tick();

      // HALT with pend[r5]=2 at issue
      do_reset();
      instr(3'd0, 0, 3'd5, 1, 0);
      tick();
      instr(3'd0, 0, 3'd0, 0, 1);
      settle(); chk("halt_t_issue", issue, 1);
      tick();
      instr(3'd1, 1, 3'd0, 0, 0);
      settle(); chk("halt_t1_issue", issue, 0); chk("halt_t1_pcstall", pc_stall, 1);
      chk("halt_t1_bub", idex_bubble, 1); chk("halt_t1_halted", halted, 0);
      tick();
      ex_redirect = 1;
      settle(); chk("halt_t2_halted", halted, 1); chk("halt_t2_flush", ifid_flush, 0);
      chk("halt_t2_issue", issue, 0);
      tick();
      settle(); chk("halt_t3_halted", halted, 1);
      tick();
      idle();
      rst = 0;
      settle(); chk("halt_rst_halted", halted, 0);
      tick();
      rst = 1;
      instr(3'd5, 1, 3'd0, 0, 0);
      settle(); chk("post_halt_issue", issue, 1); chk("post_halt_halted", halted, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
